multicycle_alu: RTL
===================

# multicycle_alu

Parametrised, iterative successor to the single-bit ALU slices. It evaluates a WIDTH-bit AND/OR/ADD/SUB/SLT/NOR operation SLICE bits per clock, LSB slice first, and carries between slices through a registered carry. It uses a valid/ready handshake on both input and output. It sits between the decode/operand-fetch stage and writeback in the multi-cycle datapath, and trades latency for a short carry chain.

## Interface
- WIDTH, 32: operand/result width; must be a multiple of SLICE, ≥ 2
- SLICE, 8: bits processed per CALC cycle; NSLICE = WIDTH/SLICE
- clk  input  1  clock, all state changes on rising edge
- rst  input  1  reset, synchronous, active-high
- in_valid  input  1  operation request
- in_ready  output  1  block can accept (high only in IDLE)
- a, b  input  WIDTH  operands
- a_invert, b_invert  input  1  invert operand; b_invert also sets LSB carry-in
- operation  input  2  00 AND, 01 OR, 10 ADD, 11 SLT
- out_valid  output  1  result/flags valid, held until accepted
- out_ready  input  1  consumer accepts result
- result  output  WIDTH  result word
- zero  output  1  result == 0
- overflow  output  1  signed overflow; ADD (op 10) only, else 0

## Operation
- States: IDLE, CALC, DONE.
- IDLE: in_ready=1. On in_valid&&in_ready, latch a^{WIDTH{a_invert}}, b^{WIDTH{b_invert}}, and operation. Set carry=b_invert and slice counter=0, then go to CALC.
- CALC: each cycle processes slice k = bits [k*SLICE +: SLICE].
  - Per bit: AND, OR, or sum = ai^bi^cin, with ripple carry inside the slice.
  - The slice carry-out is registered as the next slice's carry-in.
  - Op 11: result bits of every slice are 0 (Less input = 0), except bit 0, which is handled below.
- Last slice (k = NSLICE-1):
  - ovf = carry into MSB ^ carry out of MSB.
  - set = MSB sum ^ ovf.
  - overflow register = ovf if op==10, else 0.
  - Op 11: result[0] = set.
  - zero is computed from the final result word.
  - Go to DONE.
- DONE: out_valid=1; result, zero, and overflow stay stable. On out_ready, go to IDLE and drop out_valid.
- Operand, op, and invert inputs are ignored outside IDLE. Changes while busy have no effect.
- Carry out of the MSB is discarded; there is no carry output.
- NOR = op 00 with a_invert=b_invert=1. SUB = op 10 with b_invert=1. SLT requires b_invert=1 to be meaningful; the block does not enforce this.

## Timing
- Reset values: state IDLE, in_ready=1, out_valid=0, result=0, zero=0, overflow=0, counter=0, carry=0.
- rst mid-CALC or in DONE aborts the operation with no output. Reset has priority over all handshakes.
- Request accepted at edge T. Slices are processed at edges T+1..T+NSLICE. out_valid=1 after edge T+NSLICE.
  - Latency is NSLICE cycles for every op (4 for defaults).
- If out_ready is high while out_valid is high at edge U, the state is IDLE after U. The earliest next accept is edge U+1.
  - Minimum issue interval is NSLICE+2 cycles.
- out_ready asserted while not out_valid is ignored.
- result/zero/overflow are updated only at the last-slice edge. Between operations they hold their previous value.
- SLICE=WIDTH (NSLICE=1) is legal: a single CALC cycle.

## Test plan
- Reset then ADD: a=0x7FFFFFFF, b=1, op 10, inv 00. Required: out_valid exactly 4 cycles after accept; result=0x80000000, overflow=1, zero=0.
- SUB with slice-crossing borrow: a=5, b=7, b_invert=1, op 10. Required: result=0xFFFFFFFE, overflow=0. Then a=b=0x12345678 gives result=0, zero=1.
- SLT:
  - a=0xFFFFFFFB (-5), b=3 gives result=1, overflow=0.
  - a=0x80000000, b=1 (sub overflows) gives result=1.
  - a=3, b=0xFFFFFFFB gives result=0, zero=1.
- NOR/AND/OR: a=0xF0F0F0F0, b=0x0F0F0000, op 00, inv 11 gives 0x00000F0F. The same operands with op 01, inv 00 give 0xFFFFF0F0.
- Backpressure and input isolation:
  - Hold out_ready=0 for 3 cycles after out_valid. Required: result stable, in_ready=0.
  - Toggle a/b and pulse in_valid while busy. Required: no effect on the result.
  - out_ready=1 then returns the block to IDLE one cycle later.
- Reset mid-operation: assert rst at the 2nd CALC cycle. Required: next cycle IDLE, out_valid=0, result=0. A fresh ADD 1+1 then returns 2 after 4 cycles.

Source files
------------

// File: rtl/multicycle_alu.sv
// Iterative AND/OR/ADD/SLT ALU, SLICE bits per cycle with registered inter-slice carry; latency NSLICE cycles.
// Valid/ready on both sides: accepts only in IDLE, holds result in DONE until out_ready.
module multicycle_alu #(
    parameter int WIDTH = 32,
    parameter int SLICE = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             a_invert,
    input  logic             b_invert,
    input  logic [1:0]       operation,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             overflow
);
    localparam int NSLICE = WIDTH / SLICE;
    localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t            state, state_nxt;
    logic [WIDTH-1:0]  opa, opb, acc;
    logic [1:0]        op;
    logic              carry;
    logic [CW-1:0]     cnt;
    logic              last;

    logic [SLICE-1:0]  s_res;
    logic              c, ai, bi, s;
    logic              c_msb_in, sum_msb, slice_cout;
    logic              ovf, set;
    logic [WIDTH-1:0]  base_word, final_word;

    assign last = (cnt == CW'(NSLICE - 1));

    // Operands shift right each CALC cycle, so the current slice is always the low SLICE bits.
    always_comb begin
        c        = carry;
        ai       = 1'b0;
        bi       = 1'b0;
        s        = 1'b0;
        s_res    = '0;
        c_msb_in = 1'b0;
        sum_msb  = 1'b0;
        for (int i = 0; i < SLICE; i++) begin
            ai = opa[i];
            bi = opb[i];
            s  = ai ^ bi ^ c;
            if (i == SLICE - 1) begin
                c_msb_in = c;
                sum_msb  = s;
            end
            case (op)
                2'b00:   s_res[i] = ai & bi;
                2'b01:   s_res[i] = ai | bi;
                2'b10:   s_res[i] = s;
                default: s_res[i] = 1'b0;
            endcase
            c = (ai & bi) | (c & (ai ^ bi));
        end
        slice_cout = c;
    end

    assign ovf = c_msb_in ^ slice_cout;
    assign set = sum_msb ^ ovf;

    // Finished slices accumulate from the top of acc downward, landing LSB-aligned after the last one.
    always_comb begin
        base_word  = (WIDTH'(s_res) << (WIDTH - SLICE)) | (acc >> SLICE);
        final_word = base_word;
        if (op == 2'b11) final_word[0] = set;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = CALC;
            end
            CALC: begin
                if (last) state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            opa      <= '0;
            opb      <= '0;
            acc      <= '0;
            op       <= 2'b00;
            carry    <= 1'b0;
            cnt      <= '0;
            result   <= '0;
            zero     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        opa   <= a ^ {WIDTH{a_invert}};
                        opb   <= b ^ {WIDTH{b_invert}};
                        op    <= operation;
                        carry <= b_invert;
                        cnt   <= '0;
                        acc   <= '0;
                    end
                end
                CALC: begin
                    opa   <= opa >> SLICE;
                    opb   <= opb >> SLICE;
                    carry <= slice_cout;
                    acc   <= base_word;
                    if (last) begin
                        cnt      <= '0;
                        result   <= final_word;
                        zero     <= (final_word == '0);
                        overflow <= (op == 2'b10) && ovf;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
